// File: rtl/ticket_issuer_if.sv
// Queue write port between the ticket issuer (master) and the customer FIFO (slave).
interface ticket_issuer_if #(
  parameter int unsigned DT_SZ = 4
);
  logic             in_valid;
  logic [DT_SZ-1:0] in_num;
  logic [DT_SZ-1:0] in_time;
  logic             q_full;

  modport master (output in_valid, output in_num, output in_time, input q_full);
  modport slave  (input in_valid, input in_num, input in_time, output q_full);
endinterface

// File: rtl/ticket_issuer.sv
// Arrival stage: debounces the customer button and issues one numbered, timed
// queue write per press; presses arriving while the queue is full are counted.
module ticket_issuer #(
  parameter int unsigned     DT_SZ     = 4,
  parameter int unsigned     DB_CYC    = 4,
  parameter logic [DT_SZ-1:0] LFSR_SEED = 4'b1001,
  parameter logic [DT_SZ-1:0] LFSR_TAPS = 4'b1100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn,
  input  logic [DT_SZ-1:0] sw_time,
  output logic [DT_SZ-1:0] drop_cnt,
  ticket_issuer_if.master  wr
);

  localparam int unsigned      CNT_W   = $clog2(DB_CYC + 1);
  localparam logic [DT_SZ-1:0] MAX_VAL = {DT_SZ{1'b1}};
  localparam logic [DT_SZ-1:0] SEED_NZ = (LFSR_SEED == '0) ? DT_SZ'(1) : LFSR_SEED;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_REL = 2'd2
  } state_t;

  logic             r_s1;
  logic             r_s2;
  logic             r_btn_db;
  logic [CNT_W-1:0] r_db_cnt;
  logic [DT_SZ-1:0] r_lfsr;
  logic             w_lfsr_fb;

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_valid;
  logic [DT_SZ-1:0] r_num;
  logic [DT_SZ-1:0] r_time;
  logic [DT_SZ-1:0] r_drop;
  logic [DT_SZ-1:0] r_next_num;

  logic             w_valid_nxt;
  logic [DT_SZ-1:0] w_num_nxt;
  logic [DT_SZ-1:0] w_time_nxt;
  logic [DT_SZ-1:0] w_drop_nxt;
  logic [DT_SZ-1:0] w_next_num_nxt;

  // Synchronizer plus debouncer: btn_db follows s2 only after DB_CYC differing cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1     <= 1'b0;
      r_s2     <= 1'b0;
      r_btn_db <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_s1 <= btn;
      r_s2 <= r_s1;
      if (r_s2 == r_btn_db) begin
        r_db_cnt <= '0;
      end else if (r_db_cnt == CNT_W'(DB_CYC - 1)) begin
        r_btn_db <= r_s2;
        r_db_cnt <= '0;
      end else begin
        r_db_cnt <= r_db_cnt + CNT_W'(1);
      end
    end
  end

  assign w_lfsr_fb = ^(r_lfsr & LFSR_TAPS);

  // Free-running Fibonacci LFSR used as the automatic service time.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lfsr <= SEED_NZ;
    end else begin
      r_lfsr <= {r_lfsr[DT_SZ-2:0], w_lfsr_fb};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (r_btn_db) w_state_nxt = wr.q_full ? WAIT_REL : ISSUE;
      ISSUE:    w_state_nxt = WAIT_REL;
      WAIT_REL: if (!r_btn_db) w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs; the strobe is loaded on the IDLE decision edge.
  always_comb begin
    w_valid_nxt    = 1'b0;
    w_num_nxt      = '0;
    w_time_nxt     = '0;
    w_drop_nxt     = r_drop;
    w_next_num_nxt = r_next_num;
    case (r_state)
      IDLE: begin
        if (r_btn_db) begin
          if (wr.q_full) begin
            if (r_drop != MAX_VAL) w_drop_nxt = r_drop + DT_SZ'(1);
          end else begin
            w_valid_nxt = 1'b1;
            w_num_nxt   = r_next_num;
            w_time_nxt  = (sw_time != '0) ? sw_time : r_lfsr;
          end
        end
      end
      ISSUE: begin
        w_next_num_nxt = (r_next_num == MAX_VAL) ? DT_SZ'(1) : r_next_num + DT_SZ'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid    <= 1'b0;
      r_num      <= '0;
      r_time     <= '0;
      r_drop     <= '0;
      r_next_num <= DT_SZ'(1);
    end else begin
      r_valid    <= w_valid_nxt;
      r_num      <= w_num_nxt;
      r_time     <= w_time_nxt;
      r_drop     <= w_drop_nxt;
      r_next_num <= w_next_num_nxt;
    end
  end

  assign wr.in_valid = r_valid;
  assign wr.in_num   = r_num;
  assign wr.in_time  = r_time;
  assign drop_cnt    = r_drop;

endmodule
